// File: rtl/rb_wb_ctrl_pkg.sv
// Shared write-back codes: op types, write-back mux selects and controller states.
package rb_wb_ctrl_pkg;

   localparam logic [1:0] OP_LINK  = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_ALU   = 2'b10;
   localparam logic [1:0] OP_NONE  = 2'b11;

   localparam logic [1:0] MXRB_PC  = 2'b00;
   localparam logic [1:0] MXRB_DM  = 2'b01;
   localparam logic [1:0] MXRB_ALU = 2'b10;

   typedef enum logic {
      ST_IDLE      = 1'b0,
      ST_LOAD_WAIT = 1'b1
   } wb_state_t;

endpackage

// File: rtl/rb_wb_ctrl_if.sv
// Write-back op handshake between the execute stage (master) and the controller (slave).
interface rb_wb_ctrl_if #(
   parameter int AW = 4
) ();
   logic          op_valid;
   logic          op_ready;
   logic [1:0]    op_type;
   logic [AW-1:0] op_rd;

   modport master (output op_valid, output op_type, output op_rd, input op_ready);
   modport slave  (input op_valid, input op_type, input op_rd, output op_ready);
endinterface

// File: rtl/wb_load_timer.sv
// Load-wait watchdog: down-counter loaded on LOAD_WAIT entry, tc on the last allowed wait cycle.
module wb_load_timer #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic run,
   output logic tc
);
   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TC_LOAD = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= TC_LOAD;
      end else if (run && (cnt != '0)) begin
         cnt <= cnt - TW'(1);
      end
   end

   assign tc = run && (cnt == '0);

endmodule

// File: rtl/rb_wb_ctrl.sv
// Register-bank write-back sequencer: mux select, write enable and address.
// Optional load-wait abort enabled by defining LOAD_TIMEOUT_EN.
//
// state        | meaning
// ST_IDLE      | accepting ops; ALU/link ops write on the next cycle
// ST_LOAD_WAIT | load accepted, waiting for dm_valid (or timeout)
module rb_wb_ctrl
   import rb_wb_ctrl_pkg::*;
#(
   parameter int AW           = 4,
   parameter bit R0_HARDWIRED = 1'b1,
   parameter int TIMEOUT_CYC  = 16,
   parameter int CW           = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   rb_wb_ctrl_if.slave   op,
   input  logic          dm_valid,
   output logic [1:0]    S_MXRB,
   output logic          W_RB,
   output logic [AW-1:0] rb_addr,
   output logic          busy,
   output logic          load_err,
   output logic [CW-1:0] wb_count
);

   wb_state_t     state, state_nx;
   logic [1:0]    mxrb_nx;
   logic [AW-1:0] addr_nx;
   logic          w_nx, busy_nx, err_nx;
   logic          load_tc;

   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("rb_wb_ctrl: TIMEOUT_CYC must be at least 2");
   end

   // Writes to r0 are dropped here so the bank never sees them; sequencing is unaffected.
   function automatic logic wr_ok(input logic [AW-1:0] rd);
      return !(R0_HARDWIRED && (rd == '0));
   endfunction

   assign op.op_ready = (state == ST_IDLE);

`ifdef LOAD_TIMEOUT_EN
   logic timer_start, timer_run;
   assign timer_start = (state == ST_IDLE) && (state_nx == ST_LOAD_WAIT);
   assign timer_run   = (state == ST_LOAD_WAIT);

   wb_load_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_load_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .start (timer_start),
      .run   (timer_run),
      .tc    (load_tc)
   );
`else
   assign load_tc = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      mxrb_nx  = S_MXRB;
      addr_nx  = rb_addr;
      w_nx     = 1'b0;
      busy_nx  = busy;
      err_nx   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (op.op_valid) begin
               case (op.op_type)
                  OP_LINK: begin
                     w_nx    = wr_ok(op.op_rd);
                     mxrb_nx = MXRB_PC;
                     addr_nx = op.op_rd;
                  end
                  OP_ALU: begin
                     w_nx    = wr_ok(op.op_rd);
                     mxrb_nx = MXRB_ALU;
                     addr_nx = op.op_rd;
                  end
                  OP_LOAD: begin
                     mxrb_nx  = MXRB_DM;
                     addr_nx  = op.op_rd;
                     busy_nx  = 1'b1;
                     state_nx = ST_LOAD_WAIT;
                  end
                  OP_NONE: ;
                  default: ;
               endcase
            end
         end
         ST_LOAD_WAIT: begin
            // dm_valid takes priority over a coincident timeout.
            if (dm_valid) begin
               w_nx     = wr_ok(rb_addr);
               busy_nx  = 1'b0;
               state_nx = ST_IDLE;
            end else if (load_tc) begin
               err_nx   = 1'b1;
               busy_nx  = 1'b0;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         S_MXRB   <= MXRB_ALU;
         W_RB     <= 1'b0;
         rb_addr  <= '0;
         busy     <= 1'b0;
         load_err <= 1'b0;
         wb_count <= '0;
      end else begin
         state    <= state_nx;
         S_MXRB   <= mxrb_nx;
         W_RB     <= w_nx;
         rb_addr  <= addr_nx;
         busy     <= busy_nx;
         load_err <= err_nx;
         wb_count <= wb_count + CW'(W_RB);
      end
   end

endmodule

// File: tb/tb_rb_wb_ctrl.sv
// Bench for rb_wb_ctrl: directed ops, behavioural model checked every cycle, literal spot checks.
module tb_rb_wb_ctrl;
   localparam int AW = 4;
   localparam int CW = 16;
   localparam int TO = 16;
`ifdef LOAD_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          dm_valid = 1'b0;
   logic [1:0]    s_mxrb;
   logic          w_rb;
   logic [AW-1:0] rb_addr;
   logic          busy;
   logic          load_err;
   logic [CW-1:0] wb_count;

   rb_wb_ctrl_if #(.AW(AW)) op_if ();

   rb_wb_ctrl #(.AW(AW), .R0_HARDWIRED(1'b1), .TIMEOUT_CYC(TO), .CW(CW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .op       (op_if.slave),
      .dm_valid (dm_valid),
      .S_MXRB   (s_mxrb),
      .W_RB     (w_rb),
      .rb_addr  (rb_addr),
      .busy     (busy),
      .load_err (load_err),
      .wb_count (wb_count)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: expected registered outputs after each edge.
   bit          m_w     = 1'b0;
   bit          m_busy  = 1'b0;
   bit          m_err   = 1'b0;
   bit [1:0]    m_mx    = 2'd2;
   bit [AW-1:0] m_addr  = '0;
   int unsigned m_cnt   = 0;
   int          m_waited = 0;
   bit          nw, nerr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_w = 0; m_busy = 0; m_err = 0; m_mx = 2'd2; m_addr = '0; m_cnt = 0; m_waited = 0;
      end else begin
         m_cnt = (m_cnt + int'(m_w)) % (1 << CW);
         nw = 0;
         nerr = 0;
         if (!m_busy) begin
            if (op_if.op_valid) begin
               if (op_if.op_type == 2'd0 || op_if.op_type == 2'd2) begin
                  nw = (op_if.op_rd != 0);
                  m_mx = op_if.op_type;
                  m_addr = op_if.op_rd;
               end else if (op_if.op_type == 2'd1) begin
                  m_mx = 2'd1;
                  m_addr = op_if.op_rd;
                  m_busy = 1;
                  m_waited = 0;
               end
            end
         end else if (dm_valid) begin
            nw = (m_addr != 0);
            m_busy = 0;
         end else if (TO_EN && m_waited == TO - 1) begin
            nerr = 1;
            m_busy = 0;
         end else begin
            m_waited++;
         end
         m_w = nw;
         m_err = nerr;
      end
   end

   always @(negedge clk) begin
      chk("mdl_op_ready", int'(op_if.op_ready), int'(!m_busy));
      chk("mdl_w_rb", int'(w_rb), int'(m_w));
      chk("mdl_s_mxrb", int'(s_mxrb), int'(m_mx));
      chk("mdl_rb_addr", int'(rb_addr), int'(m_addr));
      chk("mdl_busy", int'(busy), int'(m_busy));
      chk("mdl_load_err", int'(load_err), int'(m_err));
      chk("mdl_wb_count", int'(wb_count), int'(m_cnt));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [1:0] t, input logic [AW-1:0] rd);
      op_if.op_valid = 1'b1;
      op_if.op_type  = t;
      op_if.op_rd    = rd;
   endtask

   task automatic lit(input string name, input logic w, input logic [1:0] mx, input logic [AW-1:0] a, input logic b);
      chk({name, "_w_rb"}, int'(w_rb), int'(w));
      chk({name, "_s_mxrb"}, int'(s_mxrb), int'(mx));
      chk({name, "_rb_addr"}, int'(rb_addr), int'(a));
      chk({name, "_busy"}, int'(busy), int'(b));
      chk({name, "_op_ready"}, int'(op_if.op_ready), int'(!b));
   endtask

   initial begin
      op_if.op_valid = 1'b0;
      op_if.op_type  = 2'd3;
      op_if.op_rd    = '0;
      #12;
      lit("reset", 1'b0, 2'd2, 4'd0, 1'b0);
      chk("reset_load_err", int'(load_err), 0);
      chk("reset_wb_count", int'(wb_count), 0);
      rst_n = 1'b1;
      #1;
      chk("ready_after_reset", int'(op_if.op_ready), 1);

      // ALU rd=5
      offer(2'd2, 4'd5); tick(); op_if.op_valid = 1'b0;
      lit("alu5", 1'b1, 2'd2, 4'd5, 1'b0);
      tick();
      chk("alu5_w_drop", int'(w_rb), 0);
      chk("alu5_count", int'(wb_count), 1);

      // link rd=3 then ALU rd=7 back to back
      offer(2'd0, 4'd3); tick();
      lit("link3", 1'b1, 2'd0, 4'd3, 1'b0);
      offer(2'd2, 4'd7); tick(); op_if.op_valid = 1'b0;
      lit("alu7", 1'b1, 2'd2, 4'd7, 1'b0);
      tick();
      chk("b2b_count", int'(wb_count), 3);

      // load rd=9, ALU rd=4 offered throughout the wait
      offer(2'd1, 4'd9); tick();
      offer(2'd2, 4'd4);
      for (int i = 1; i <= 4; i++) begin
         lit($sformatf("ldwait%0d", i), 1'b0, 2'd1, 4'd9, 1'b1);
         if (i == 4) dm_valid = 1'b1;
         tick();
      end
      dm_valid = 1'b0;
      lit("ld9_write", 1'b1, 2'd1, 4'd9, 1'b0);
      tick(); op_if.op_valid = 1'b0;
      lit("alu4_after_load", 1'b1, 2'd2, 4'd4, 1'b0);
      tick();
      chk("load_count", int'(wb_count), 5);

      // r0 suppression and no-write op
      offer(2'd2, 4'd0); tick();
      lit("alu_r0", 1'b0, 2'd2, 4'd0, 1'b0);
      offer(2'd3, 4'd6); tick();
      lit("none_op", 1'b0, 2'd2, 4'd0, 1'b0);
      offer(2'd1, 4'd0); tick(); op_if.op_valid = 1'b0;
      dm_valid = 1'b1; tick(); dm_valid = 1'b0;
      lit("load_r0", 1'b0, 2'd1, 4'd0, 1'b0);
      dm_valid = 1'b1; tick(); dm_valid = 1'b0;
      lit("dm_in_idle", 1'b0, 2'd1, 4'd0, 1'b0);
      tick();
      chk("r0_count", int'(wb_count), 5);

`ifdef LOAD_TIMEOUT_EN
      offer(2'd1, 4'd2); tick(); op_if.op_valid = 1'b0;
      for (int i = 1; i <= TO; i++) begin
         chk($sformatf("to_busy%0d", i), int'(busy), 1);
         tick();
      end
      lit("timeout", 1'b0, 2'd1, 4'd2, 1'b0);
      chk("timeout_err", int'(load_err), 1);
      tick();
      chk("timeout_err_drop", int'(load_err), 0);
      offer(2'd1, 4'd2); tick(); op_if.op_valid = 1'b0;
      for (int i = 1; i <= TO; i++) begin
         if (i == TO) dm_valid = 1'b1;
         tick();
      end
      dm_valid = 1'b0;
      lit("tc_dm_write", 1'b1, 2'd1, 4'd2, 1'b0);
      chk("tc_dm_no_err", int'(load_err), 0);
`else
      offer(2'd1, 4'd2); tick(); op_if.op_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         chk($sformatf("long_busy%0d", i), int'(busy), 1);
         chk($sformatf("long_err%0d", i), int'(load_err), 0);
         tick();
      end
      dm_valid = 1'b1; tick(); dm_valid = 1'b0;
      lit("long_write", 1'b1, 2'd1, 4'd2, 1'b0);
`endif
      tick();
      chk("pre_reset_count", int'(wb_count), 6);

      // reset mid-LOAD_WAIT, then dm_valid must not write
      offer(2'd1, 4'd11); tick(); op_if.op_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      lit("midreset", 1'b0, 2'd2, 4'd0, 1'b0);
      chk("midreset_count", int'(wb_count), 0);
      dm_valid = 1'b1;
      #2 rst_n = 1'b1;
      tick(); tick();
      dm_valid = 1'b0;
      lit("post_reset", 1'b0, 2'd2, 4'd0, 1'b0);
      chk("post_reset_count", int'(wb_count), 0);
      tick(); tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
